// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID pipeline queue between fetch and decode.
// A DEPTH-entry FIFO of (pc, insn) pairs with ready/valid handshakes on both
// sides, registered outputs, and a flush input for taken-jump redirects.
// Optional build macro IFQ_PERF_EN adds the 16-bit saturating stall_cnt port.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INSN_W-1:0] in_insn,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INSN_W-1:0] out_insn,
  input  logic              out_ready,
  input  logic              flush
`ifdef IFQ_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INSN_W-1:0] r_insn_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_last_pc;
  logic [INSN_W-1:0] r_last_insn;

  logic w_push;
  logic w_pop;
  logic w_not_empty;

  // Handshakes are derived only from registered state, so in_ready never
  // depends on out_ready and a full queue rejects a push even while popping.
  assign w_not_empty = (r_count != '0);
  assign in_ready    = (r_count < FULL_CNT);
  assign out_valid   = w_not_empty;
  assign w_push      = in_valid & in_ready;
  assign w_pop       = w_not_empty & out_ready;

  // Head entry while non-empty; otherwise the value shown on the previous cycle.
  assign out_pc   = w_not_empty ? r_pc_mem[r_rd_ptr]   : r_last_pc;
  assign out_insn = w_not_empty ? r_insn_mem[r_rd_ptr] : r_last_insn;

  // Pointer and occupancy update; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage write; a push coinciding with flush is dropped.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the entry array sits under the async reset because reset must
    // leave every slot at zero, not just the pointers.
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_insn_mem[i] <= '0;
      end
    end else if (w_push && !flush) begin
      r_pc_mem[r_wr_ptr]   <= in_pc;
      r_insn_mem[r_wr_ptr] <= in_insn;
    end
  end

  // Remember what was on the outputs so they hold while the queue is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_pc   <= '0;
      r_last_insn <= '0;
    end else begin
      r_last_pc   <= out_pc;
      r_last_insn <= out_insn;
    end
  end

`ifdef IFQ_PERF_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of edges where decode holds back a valid head; flush
  // does not clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_not_empty && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter ADDR_W, 32, PC width.
REQ-002 SHALL have parameter INSN_W, 32, instruction width.
REQ-003 SHALL have parameter DEPTH, 2, entry count; power of two, minimum 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  fetch stage presents a pc/insn pair.
REQ-007 SHALL have port in_pc  input  ADDR_W  PC of the fetched instruction.
REQ-008 SHALL have port in_insn  input  INSN_W  fetched instruction word.
REQ-009 SHALL have port in_ready  output  1  queue accepts the pair; drives the PC wrEnable (PC holds while low).
REQ-010 SHALL have port out_valid  output  1  head entry is valid for decode.
REQ-011 SHALL have port out_pc  output  ADDR_W  head PC.
REQ-012 SHALL have port out_insn  output  INSN_W  head instruction.
REQ-013 SHALL have port out_ready  input  1  decode consumes the head this cycle.
REQ-014 SHALL have port flush  input  1  redirect (jump taken); discards all queued entries.
REQ-015 SHALL have port stall_cnt  output  16  cycles with out_valid=1 and out_ready=0; present only with IFQ_PERF_EN.

Function
REQ-016 SHALL push when in_valid and in_ready are both 1 at a clock edge; pop when out_valid and out_ready are both 1.
REQ-017 SHALL drive in_ready = (count < DEPTH), derived only from registered count; no dependency on out_ready.
REQ-018 SHALL drive out_valid = (count != 0); out_pc/out_insn SHALL come from the registered head entry.
REQ-019 SHALL have one-cycle latency: a pair pushed at edge N is visible on the outputs after edge N; no combinational in-to-out bypass.
REQ-020 SHALL keep count unchanged and advance both pointers on a simultaneous push and pop.
REQ-021 SHALL wrap read and write pointers modulo DEPTH.
REQ-022 SHALL accept no push while full, even when a pop occurs that cycle; in_ready is 0 for that whole cycle.
REQ-023 SHALL ignore out_ready when empty: no pop, and count does not underflow.
REQ-024 SHALL, when flush=1 at an edge, set count=0 and both pointers=0, and drop any same-cycle push or pop; flush has priority.
REQ-025 SHALL hold out_pc/out_insn at their last value while empty; consumers qualify them with out_valid only.
REQ-026 SHALL hold head data stable while out_valid=1 and out_ready=0.

Reset
REQ-027 SHALL, when rst=0, immediately clear count, pointers and all entry storage to 0, independent of clk.
REQ-028 SHALL drive in_ready=1, out_valid=0, out_pc=0, out_insn=0 and stall_cnt=0 while rst=0 and after its release.
REQ-029 SHALL abandon any in-flight push or pop when reset asserts mid-operation; first push is accepted on the first edge with rst=1.

Configuration
REQ-030 SHALL implement the stall_cnt port and a 16-bit saturating counter only when IFQ_PERF_EN is defined; the counter increments on each edge with out_valid=1 and out_ready=0, holds at 0xFFFF, and is not cleared by flush.
REQ-031 SHALL, without IFQ_PERF_EN, omit the port and counter entirely, with no other change in behaviour.

Verification
REQ-032 SHALL cover: reset, then push pc=0x0 insn=0x00000013 at edge 1 -> out_valid=1, out_pc=0x0, out_insn=0x00000013 after edge 1, not before.
REQ-033 SHALL cover: out_ready=0, push 0x0 and 0x4 -> in_ready=0 after the 2nd edge; a 3rd pair offered with out_ready=1 -> 0x0 pops, 3rd pair rejected, count=1.
REQ-034 SHALL cover: full with head 0x8, flush=1 with in_valid=1 and out_ready=1 at the same edge -> count=0, out_valid=0, in_ready=1; next push 0x40 appears at head.
REQ-035 SHALL cover: continuous push/pop for 8 cycles with PCs 0x0..0x1C -> outputs 0x0..0x1C in order with no gaps after the first cycle (pointer wrap).
REQ-036 SHALL cover: rst driven low between edges with 2 entries queued -> out_valid=0 and in_ready=1 before the next clk edge.
REQ-037 SHALL cover: with IFQ_PERF_EN, out_valid=1 and out_ready=0 for 5 edges -> stall_cnt=5; a flush leaves it at 5.
